// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access controller.
package mem_access_pkg;

    localparam int DBUS_W = 64;
    localparam int STRB_W = DBUS_W / 8;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [STRB_W-1:0] strobe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // is_unsigned rides along with the request so the response can be extended later
    typedef struct packed {
        logic              write;
        msize_t            size;
        logic              is_unsigned;
        strobe_t           strobe;
        logic [DBUS_W-1:0] addr;
        logic [DBUS_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              data_ok;
        logic [DBUS_W-1:0] data;
    } dbus_resp_t;

    function automatic logic [DBUS_W-1:0] size_mask(msize_t s);
        logic [DBUS_W-1:0] m;
        case (s)
            MSIZE1:  m = 64'h0000_0000_0000_00FF;
            MSIZE2:  m = 64'h0000_0000_0000_FFFF;
            MSIZE4:  m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        return m;
    endfunction

    function automatic strobe_t size_strobe(msize_t s);
        strobe_t st;
        case (s)
            MSIZE1:  st = 8'h01;
            MSIZE2:  st = 8'h03;
            MSIZE4:  st = 8'h0F;
            default: st = 8'hFF;
        endcase
        return st;
    endfunction

    // (1 << s) - 1 wraps to 3'b111 for dwords, which is exactly the low-bit mask needed
    function automatic logic is_misaligned(logic [2:0] off, msize_t s);
        return |(off & ((3'b001 << s) - 3'b001));
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Byte-lane alignment: store shift/strobe generation and load extract/extend.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rline,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [7:0]        strobe,
    output logic [DATA_W-1:0] rdata
);
    msize_t            sz;
    logic [DATA_W-1:0] rshift;
    logic [DATA_W-1:0] rmask;
    logic              sign;

    always_comb begin
        sz         = msize_t'(size);
        // bytes pushed past lane 7 are dropped on purpose (unaligned, unchecked build)
        wdata_lane = wdata << {off, 3'b000};
        strobe     = size_strobe(sz) << off;
        rshift     = rline >> {off, 3'b000};
        rmask      = DATA_W'(size_mask(sz));
        case (sz)
            MSIZE1:  sign = rshift[7];
            MSIZE2:  sign = rshift[15];
            MSIZE4:  sign = rshift[31];
            default: sign = rshift[DATA_W-1];
        endcase
        rdata = (rshift & rmask) | ((!is_unsigned && sign) ? ~rmask : '0);
    end

endmodule

// File: rtl/mem_access.sv
// Data-memory access controller: execute-stage load/store -> held-valid bus request.
// Optional misalignment trap selected by MEM_ALIGN_CHECK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [1:0]        in_msize,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              stall_in,
    output logic              dreq_valid,
    output logic              dreq_write,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic [DATA_W-1:0] memread_data,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              misalign
);
    mem_state_t        state_q, state_d;
    dbus_req_t         req_q, req_d;
    dbus_resp_t        resp;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              access;
    logic              in_idle;
    logic [DATA_W-1:0] wdata_lane, rdata_ext;
    logic [7:0]        strobe_lane;

    assign access  = in_valid & (in_memread | in_memwrite);
    assign in_idle = (state_q == IDLE);
    assign resp    = '{data_ok: dresp_data_ok, data: DBUS_W'(dresp_data)};

    // One aligner: fed from the execute inputs while idle, from the latch while busy.
    mem_lane_align #(.DATA_W(DATA_W)) u_lane (
        .off         (in_idle ? in_addr[2:0] : req_q.addr[2:0]),
        .size        (in_idle ? in_msize     : req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (in_wdata),
        .rline       (resp.data[DATA_W-1:0]),
        .wdata_lane  (wdata_lane),
        .strobe      (strobe_lane),
        .rdata       (rdata_ext)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        dreq_valid = 1'b0;
        mem_stall  = 1'b0;
        mem_done   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                mem_stall = access;
                if (access) begin
                    // memread+memwrite together is a store
                    req_d.write       = in_memwrite;
                    req_d.size        = msize_t'(in_msize);
                    req_d.is_unsigned = in_unsigned;
                    req_d.addr        = DBUS_W'(in_addr);
                    req_d.data        = DBUS_W'(wdata_lane);
                    req_d.strobe      = strobe_lane;
                    state_d           = BUSY;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_d = is_misaligned(in_addr[2:0], msize_t'(in_msize));
                    if (misalign_d) begin
                        rdata_d = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                dreq_valid = 1'b1;
                mem_stall  = 1'b1;
                if (resp.data_ok) begin
                    rdata_d = req_q.write ? '0 : rdata_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                mem_done = 1'b1;
                if (!stall_in) begin
                    state_d = IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign dreq_write   = req_q.write;
    assign dreq_addr    = req_q.addr[ADDR_W-1:0];
    assign dreq_size    = req_q.size;
    assign dreq_strobe  = req_q.strobe;
    assign dreq_data    = req_q.data[DATA_W-1:0];
    assign memread_data = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset abort, randomized loads/stores vs byte model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_memread, in_memwrite, in_unsigned, stall_in;
    logic [1:0]  in_msize;
    logic [63:0] in_addr, in_wdata;
    logic        dreq_valid, dreq_write;
    logic [63:0] dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_data_ok;
    logic [63:0] dresp_data, memread_data;
    logic        mem_done, mem_stall, misalign;

    int errors = 0;
    int checks = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    mem_access dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_msize(in_msize), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .stall_in(stall_in),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .memread_data(memread_data), .mem_done(mem_done), .mem_stall(mem_stall),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr, wdata, line;
        int          wt, st;
        logic [63:0] exp_rdata;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model works byte by byte, straight from the lane rules.
    function automatic logic [63:0] m_load(logic [63:0] line, logic [63:0] addr, logic [1:0] sz, logic uns);
        int o = int'(addr[2:0]);
        int n = 1 << sz;
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) if (o + i < 8) r[8*i +: 8] = line[8*(o+i) +: 8];
        if (!uns) for (int i = 8*n; i < 64; i++) r[i] = r[8*n-1];
        return r;
    endfunction

    function automatic logic [7:0] m_strobe(logic [63:0] addr, logic [1:0] sz);
        int o = int'(addr[2:0]);
        logic [7:0] s = '0;
        for (int i = 0; i < (1 << sz); i++) if (o + i < 8) s[o+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(logic [63:0] wdata, logic [63:0] addr);
        int o = int'(addr[2:0]);
        logic [63:0] d = '0;
        for (int b = o; b < 8; b++) d[8*b +: 8] = wdata[8*(b-o) +: 8];
        return d;
    endfunction

    // Starts and ends just after a rising edge with the DUT idle.
    task automatic run_txn(input vec_t t, input string nm);
        logic acc, skip;
        int   nstall;
        acc  = t.v & (t.rd | t.wr);
        skip = ALIGN_EN && acc && ((t.addr % (64'd1 << t.sz)) != 0);
        in_valid = t.v; in_memread = t.rd; in_memwrite = t.wr; in_msize = t.sz;
        in_unsigned = t.uns; in_addr = t.addr; in_wdata = t.wdata;
        stall_in = 1'($urandom);
        @(negedge clk);
        chk({nm, ".idle_stall"}, 64'(mem_stall), 64'(acc));
        chk({nm, ".idle_valid"}, 64'(dreq_valid), 64'd0);
        @(posedge clk); #1;
        if (!acc) begin
            in_valid = 1'b0; stall_in = 1'b0;
            return;
        end
        // junk on in_* while the access is in flight must be ignored
        in_memread = 1'($urandom); in_memwrite = 1'($urandom); in_msize = 2'($urandom);
        in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        nstall = 1;
        if (!skip) begin
            for (int w = 0; w <= t.wt; w++) begin
                dresp_data_ok = (w == t.wt);
                dresp_data    = dresp_data_ok ? t.line : {$urandom, $urandom};
                stall_in      = 1'($urandom);
                @(negedge clk);
                chk({nm, ".busy_valid"}, 64'(dreq_valid), 64'd1);
                chk({nm, ".busy_write"}, 64'(dreq_write), 64'(t.wr));
                chk({nm, ".busy_addr"}, dreq_addr, t.addr);
                chk({nm, ".busy_size"}, 64'(dreq_size), 64'(t.sz));
                chk({nm, ".busy_done"}, 64'(mem_done), 64'd0);
                if (t.wr) begin
                    chk({nm, ".strobe"}, 64'(dreq_strobe), 64'(t.exp_strb));
                    chk({nm, ".wdata"}, dreq_data, t.exp_wdata);
                end
                if (mem_stall) nstall++;
                @(posedge clk); #1;
            end
            dresp_data_ok = 1'b0;
            dresp_data    = {$urandom, $urandom};
            chk({nm, ".stall_cycles"}, 64'(nstall), 64'(2 + t.wt));
        end
        for (int s = 0; s <= t.st; s++) begin
            stall_in = (s < t.st);
            if (s == t.st) in_valid = 1'b0;
            @(negedge clk);
            chk({nm, ".done"}, 64'(mem_done), 64'd1);
            chk({nm, ".done_stall"}, 64'(mem_stall), 64'd0);
            chk({nm, ".done_valid"}, 64'(dreq_valid), 64'd0);
            chk({nm, ".rdata"}, memread_data, t.exp_rdata);
            chk({nm, ".misalign"}, 64'(misalign), 64'(skip));
            @(posedge clk); #1;
        end
        stall_in = 1'b0;
        @(negedge clk);
        chk({nm, ".bubble_done"}, 64'(mem_done), 64'd0);
        chk({nm, ".bubble_valid"}, 64'(dreq_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".valid"}, 64'(dreq_valid), 64'd0);
        chk({nm, ".write"}, 64'(dreq_write), 64'd0);
        chk({nm, ".addr"}, dreq_addr, 64'd0);
        chk({nm, ".size"}, 64'(dreq_size), 64'd0);
        chk({nm, ".strobe"}, 64'(dreq_strobe), 64'd0);
        chk({nm, ".data"}, dreq_data, 64'd0);
        chk({nm, ".rdata"}, memread_data, 64'd0);
        chk({nm, ".done"}, 64'(mem_done), 64'd0);
        chk({nm, ".stall"}, 64'(mem_stall), 64'd0);
        chk({nm, ".misalign"}, 64'(misalign), 64'd0);
    endtask

    initial begin
        vec_t r;
        //          v     rd    wr    sz    uns   addr        wdata                  line                   wt st exp_rdata                  strb   exp_wdata
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h1000, 64'h0, 64'h1122334455667788, 3, 0, 64'h1122334455667788, 8'h00, 64'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 64'h1000, 64'h55, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h1008, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 64'h0, 8'h00, 64'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000000080000000, 1, 0, 64'hFFFFFFFFFFFFFF80, 8'h00, 64'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'h0, 64'h0000000080000000, 1, 0, 64'h0000000000000080, 8'h00, 64'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hABCD, 64'hFFFFFFFFFFFFFFFF, 4, 0, 64'h0, 8'hC0, 64'hABCD000000000000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h1004, 64'h0, 64'hDEADBEEF00000000, 0, 2, 64'hFFFFFFFFDEADBEEF, 8'h00, 64'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 64'h0102, 64'h0, 64'h000000007FFF0000, 1, 0, 64'h0000000000007FFF, 8'h00, 64'h0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 64'h4000, 64'h0, 64'h1234567887654321, 2, 1, 64'h0000000087654321, 8'h00, 64'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 64'h5004, 64'hCAFEF00D, 64'hFFFFFFFFFFFFFFFF, 1, 0, 64'h0, 8'hF0, 64'hCAFEF00D00000000};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 64'h3000, 64'h0123456789ABCDEF, 64'h0, 1, 1, 64'h0, 8'hFF, 64'h0123456789ABCDEF};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 64'h3007, 64'hA5, 64'h0, 2, 0, 64'h0, 8'h80, 64'hA500000000000000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 64'h3008, 64'h0, 64'h8000000000000001, 0, 0, 64'h8000000000000001, 8'h00, 64'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0011223344556677, 1, 0,
                    ALIGN_EN ? 64'h0 : 64'h0000000022334455, 8'h00, 64'h0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h1001, 64'h0, 64'h8877665544332211, 0, 1,
                    ALIGN_EN ? 64'h0 : 64'h0088776655443322, 8'h00, 64'h0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 64'h2006, 64'h11223344, 64'h0, 1, 0, 64'h0, 8'hC0, 64'h3344000000000000};

        reset = 1'b0;
        in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_msize = 2'd0;
        in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; stall_in = 1'b0;
        dresp_data_ok = 1'b0; dresp_data = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // reset while a load is on the bus, then a clean load afterwards
        run_txn(tbl[12], "pre_abort");
        in_valid = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0; in_msize = 2'd3;
        in_unsigned = 1'b0; in_addr = 64'h6000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort.busy_valid", 64'(dreq_valid), 64'd1);
        #2 reset = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_txn(tbl[0], "post_abort");

        for (int i = 0; i < 80; i++) begin
            r.v   = ($urandom_range(0, 9) != 0);
            r.rd  = 1'($urandom);
            r.wr  = 1'($urandom);
            r.sz  = 2'($urandom);
            r.uns = 1'($urandom);
            r.addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) r.addr = r.addr & ~((64'd1 << r.sz) - 64'd1);
            r.wdata = {$urandom, $urandom};
            r.line  = {$urandom, $urandom};
            r.wt = $urandom_range(0, 3);
            r.st = $urandom_range(0, 2);
            r.exp_strb  = m_strobe(r.addr, r.sz);
            r.exp_wdata = m_wdata(r.wdata, r.addr);
            r.exp_rdata = (r.wr || (ALIGN_EN && (r.addr % (64'd1 << r.sz)) != 0)) ? 64'h0
                                                                                  : m_load(r.line, r.addr, r.sz, r.uns);
            run_txn(r, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
